multi_port_arbiter: RTL and testbench

MULTI_PORT_ARBITER -- requirements
Module: multi_port_arbiter

---
 rtl/multi_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_multi_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_arbiter.sv
// Multi-port SRAM-like to single bus arbiter with per-port size/alignment checking.
// Define ARB_ROUND_ROBIN_EN for round-robin grant order; otherwise fixed priority (port 0 highest).

module mpa_port_decode (
  input  logic       i_en,
  input  logic [3:0] i_wen,
  input  logic [1:0] i_addr_lo,
  output logic       o_wr,
  output logic [1:0] o_size,
  output logic       o_err
);
  logic w_bad_wen;

  always_comb begin
    w_bad_wen = 1'b0;
    o_size    = 2'b10;
    case (i_wen)
      4'b0000, 4'b1111:                   o_size = 2'b10;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = 2'b00;
      4'b0011, 4'b1100:                   o_size = 2'b01;
      default:                            w_bad_wen = 1'b1;
    endcase
  end

  assign o_wr  = |i_wen;
  assign o_err = i_en & (w_bad_wen |
                         ((o_size == 2'b01) & i_addr_lo[0]) |
                         ((o_size == 2'b10) & (|i_addr_lo)));
endmodule

module multi_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        port_en,
  input  logic [4*NUM_PORTS-1:0]      port_wen,
  input  logic [ADDR_W*NUM_PORTS-1:0] port_addr,
  input  logic [32*NUM_PORTS-1:0]     port_wdata,
  output logic [32*NUM_PORTS-1:0]     port_rdata,
  output logic [NUM_PORTS-1:0]        port_stall,
  output logic [NUM_PORTS-1:0]        port_err,
  output logic                        stall,
  output logic                        bus_req,
  output logic                        bus_wr,
  output logic [1:0]                  bus_size,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [31:0]                 bus_wdata,
  input  logic [31:0]                 bus_rdata,
  input  logic                        bus_addr_ok,
  input  logic                        bus_data_ok
);
  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                           r_state;
  logic [NUM_PORTS-1:0]             r_pending;
  logic [GW-1:0]                    r_grant;
  logic [NUM_PORTS-1:0][31:0]       r_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0]                    r_last;
`endif

  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_PORTS-1:0][31:0]       w_wdata;
  logic [NUM_PORTS-1:0][1:0]        w_size;
  logic [NUM_PORTS-1:0]             w_wr;
  logic [NUM_PORTS-1:0]             w_valid;
  logic [NUM_PORTS-1:0]             w_remain;

  assign w_addr  = port_addr;
  assign w_wdata = port_wdata;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dec
    mpa_port_decode u_dec (
      .i_en      (port_en[g]),
      .i_wen     (port_wen[4*g +: 4]),
      .i_addr_lo (w_addr[g][1:0]),
      .o_wr      (w_wr[g]),
      .o_size    (w_size[g]),
      .o_err     (port_err[g])
    );
  end

  assign w_valid = port_en & ~port_err;

  always_comb begin
    w_remain          = r_pending;
    w_remain[r_grant] = 1'b0;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Lowest k wins: first requester found walking upward from last+1.
  function automatic logic [GW-1:0] f_select(input logic [NUM_PORTS-1:0] v,
                                             input logic [GW-1:0] last);
    logic [GW-1:0] sel;
    int            idx;
    sel = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (v[idx]) sel = GW'(idx);
    end
    return sel;
  endfunction
`else
  function automatic logic [GW-1:0] f_select(input logic [NUM_PORTS-1:0] v);
    logic [GW-1:0] sel;
    sel = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (v[k]) sel = GW'(k);
    return sel;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_grant   <= '0;
      r_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last    <= GW'(NUM_PORTS - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pending <= w_valid;
          if (|w_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            r_grant <= f_select(w_valid, r_last);
`else
            r_grant <= f_select(w_valid);
`endif
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
`ifdef ARB_ROUND_ROBIN_EN
          r_last <= r_grant;
`endif
          if (bus_addr_ok) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus_data_ok) begin
            if (!w_wr[r_grant]) r_rdata[r_grant] <= bus_rdata;
            r_pending <= w_remain;
            if (|w_remain) begin
`ifdef ARB_ROUND_ROBIN_EN
              r_grant <= f_select(w_remain, r_last);
`else
              r_grant <= f_select(w_remain);
`endif
              r_state <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus fields follow the granted port; masters hold them stable while stalled.
  assign bus_req    = (r_state == S_REQ);
  assign bus_wr     = w_wr[r_grant];
  assign bus_size   = w_size[r_grant];
  assign bus_addr   = w_addr[r_grant];
  assign bus_wdata  = w_wdata[r_grant];
  assign port_rdata = r_rdata;
  assign port_stall = r_pending;
  assign stall      = |r_pending;
endmodule

// File: tb/tb_multi_port_arbiter.sv
// Bench for multi_port_arbiter: directed scenarios plus randomized traffic against a set-based model.
module tb_multi_port_arbiter;
  localparam int P  = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [P-1:0]    port_en;
  logic [4*P-1:0]  port_wen;
  logic [AW*P-1:0] port_addr;
  logic [32*P-1:0] port_wdata;
  logic [32*P-1:0] port_rdata;
  logic [P-1:0]    port_stall, port_err;
  logic            stall, bus_req, bus_wr;
  logic [1:0]      bus_size;
  logic [AW-1:0]   bus_addr;
  logic [31:0]     bus_wdata, bus_rdata;
  logic            bus_addr_ok, bus_data_ok;

  multi_port_arbiter #(.NUM_PORTS(P), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .port_en(port_en), .port_wen(port_wen),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata),
    .port_stall(port_stall), .port_err(port_err), .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: set of ports still owed an access, the one on the bus, and whether its address was taken.
  logic [P-1:0] m_owed;
  int           m_cur, m_last;
  bit           m_wait;
  logic [31:0]  m_rd[P];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [3:0]    wen_of(int i);   return port_wen[4*i +: 4];    endfunction
  function automatic logic [AW-1:0] addr_of(int i);  return port_addr[AW*i +: AW]; endfunction
  function automatic logic [31:0]   wdata_of(int i); return port_wdata[32*i +: 32]; endfunction

  function automatic logic [1:0] exp_size(logic [3:0] w);
    if (w == 4'h0 || w == 4'hF) return 2'b10;
    if ($countones(w) == 1) return 2'b00;
    return 2'b01;
  endfunction

  function automatic bit exp_illegal(logic [3:0] w, logic [AW-1:0] a);
    bit ok_w;
    ok_w = (w == 4'h0) || ($countones(w) == 1) || (w == 4'h3) || (w == 4'hC) || (w == 4'hF);
    if (!ok_w) return 1'b1;
    case (exp_size(w))
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [P-1:0] exp_err();
    logic [P-1:0] e;
    for (int i = 0; i < P; i++) e[i] = port_en[i] & exp_illegal(wen_of(i), addr_of(i));
    return e;
  endfunction

  function automatic int sel(logic [P-1:0] v);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= P; k++) if (v[(m_last + k) % P]) return (m_last + k) % P;
`else
    for (int k = 0; k < P; k++) if (v[k]) return k;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_owed = '0; m_wait = 1'b0; m_cur = 0; m_last = P - 1;
    for (int i = 0; i < P; i++) m_rd[i] = '0;
  endtask

  task automatic model_step();
    logic [P-1:0] v;
    v = port_en & ~exp_err();
    if (m_owed == '0) begin
      m_owed = v;
      if (v != '0) begin m_cur = sel(v); m_last = m_cur; m_wait = 1'b0; end
    end else if (!m_wait) begin
      if (bus_addr_ok) m_wait = 1'b1;
    end else if (bus_data_ok) begin
      if (wen_of(m_cur) == 4'h0) m_rd[m_cur] = bus_rdata;
      m_owed[m_cur] = 1'b0;
      if (m_owed != '0) begin m_cur = sel(m_owed); m_last = m_cur; m_wait = 1'b0; end
    end
  endtask

  task automatic check_comb();
    chk("port_err", 64'(port_err), 64'(exp_err()));
    if (m_owed != '0 && !m_wait) begin
      chk("bus_addr",  64'(bus_addr),  64'(addr_of(m_cur)));
      chk("bus_wr",    64'(bus_wr),    64'(wen_of(m_cur) != 4'h0));
      chk("bus_size",  64'(bus_size),  64'(exp_size(wen_of(m_cur))));
      chk("bus_wdata", 64'(bus_wdata), 64'(wdata_of(m_cur)));
    end
  endtask

  task automatic check_reg();
    chk("bus_req",    64'(bus_req),    64'(m_owed != '0 && !m_wait));
    chk("port_stall", 64'(port_stall), 64'(m_owed));
    chk("stall",      64'(stall),      64'(m_owed != '0));
    for (int i = 0; i < P; i++)
      chk($sformatf("port_rdata%0d", i), 64'(port_rdata[32*i +: 32]), 64'(m_rd[i]));
  endtask

  // Called just after a rising edge with this cycle's inputs applied.
  task automatic tick();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_reg();
  endtask

  task automatic idle_inputs();
    port_en = '0; port_wen = '0; port_addr = '0; port_wdata = '0;
    bus_rdata = '0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  task automatic set_port(int i, bit en, logic [3:0] w, logic [AW-1:0] a, logic [31:0] d);
    port_en[i] = en; port_wen[4*i +: 4] = w; port_addr[AW*i +: AW] = a; port_wdata[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    check_reg();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int        order[4];
  int        ng;
  int        exp_order[4] = '{0, 1, 0, 1};
  logic [3:0] wtab[10] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5};

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Single read on port 0
    set_port(0, 1, 4'h0, 32'h100, 32'h0);
    tick();
    chk("r19_bus_req_c1", 64'(bus_req), 64'd1);
    chk("r19_size_c1", 64'(bus_size), 64'd2);
    chk("r19_stall_c1", 64'(port_stall), 64'b01);
    bus_addr_ok = 1'b1;
    tick();
    chk("r19_stall_c2", 64'(port_stall), 64'b01);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick();
    chk("r19_rdata_c3", 64'(port_rdata[31:0]), 64'hDEADBEEF);
    chk("r19_stall_c3", 64'(port_stall), 64'b00);
    idle_inputs();
    tick();

    // Write on port 0 and read on port 1 in the same cycle
    set_port(0, 1, 4'h3, 32'h202, 32'hA5A5_5A5A);
    set_port(1, 1, 4'h0, 32'h300, 32'h0);
    tick();
    chk("r20_wr_first", 64'(bus_wr), 64'd1);
    chk("r20_size_half", 64'(bus_size), 64'b01);
    chk("r20_addr_first", 64'(bus_addr), 64'h202);
    chk("r20_both_stall", 64'(port_stall), 64'b11);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_0000;
    tick();
    chk("r20_addr_second", 64'(bus_addr), 64'h300);
    chk("r20_stall_p1_only", 64'(port_stall), 64'b10);
    port_en[0] = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    chk("r20_rdata1", 64'(port_rdata[63:32]), 64'h1234_5678);
    chk("r20_rdata0_kept", 64'(port_rdata[31:0]), 64'hDEADBEEF);
    chk("r20_stall_done", 64'(stall), 64'd0);
    idle_inputs();
    tick();

    // Illegal wen on port 1, then misaligned word read on port 0
    set_port(1, 1, 4'h5, 32'h10, 32'h0);
    #1;
    chk("r21_err", 64'(port_err), 64'b10);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("r21_no_req", 64'(bus_req), 64'd0);
      chk("r21_no_stall", 64'(port_stall), 64'd0);
    end
    idle_inputs();
    set_port(0, 1, 4'h0, 32'h102, 32'h0);
    #1;
    chk("r24_err", 64'(port_err), 64'b01);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("r24_no_req", 64'(bus_req), 64'd0);
    end
    idle_inputs();
    tick();

    // Reset while waiting for data, late data_ok afterwards
    set_port(0, 1, 4'h0, 32'h400, 32'h0);
    tick();
    bus_addr_ok = 1'b1;
    tick();
    do_reset();
    chk("r23_rdata0_rst", 64'(port_rdata), 64'd0);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    chk("r23_no_req", 64'(bus_req), 64'd0);
    chk("r23_no_stall", 64'(stall), 64'd0);
    chk("r23_rdata_zero", 64'(port_rdata), 64'd0);
    idle_inputs();
    tick();

    // Both ports requesting continuously
    for (int i = 0; i < 4; i++) order[i] = -1;
    ng = 0;
    set_port(0, 1, 4'h0, 32'h500, 32'h0);
    set_port(1, 1, 4'h0, 32'h600, 32'h0);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1111_0000;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (bus_req) begin order[ng] = (bus_addr == 32'h600) ? 1 : 0; ng++; end
      tick();
    end
    for (int i = 0; i < 4; i++) chk($sformatf("r22_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
    port_en = '0;
    for (int c = 0; c < 10 && m_owed != '0; c++) tick();
    idle_inputs();
    tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int i = 0; i < P; i++) begin
        if (!m_owed[i]) begin
          logic [AW-1:0] a;
          a = $urandom;
          if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
          set_port(i, $urandom_range(0, 1) == 1, wtab[$urandom_range(0, 9)], a, $urandom);
        end
      end
      bus_addr_ok = $urandom_range(0, 1) == 1;
      bus_data_ok = $urandom_range(0, 2) != 0;
      bus_rdata   = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
